// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding, the bubble instruction
// and the IF/ID register layout that the decoder also consumes.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_stage.sv
// PC register and IF/ID pipeline register; handles boot bubble, stall,
// redirect with flush and a sticky misaligned-redirect fault.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] BASE_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_pc_o,
  input  logic [31:0] imem_instr_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus4_o,
  output logic [31:0] if_id_instr_o,
  output logic        fault_o,
  output logic [31:0] fetch_count_o
);

  localparam if_id_t IF_ID_RESET = '{
    valid:    1'b0,
    pc:       BASE_PC,
    pc_plus4: BASE_PC + 32'd4,
    instr:    NOP_INSTR
  };

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;
  if_id_t       if_id_q, if_id_d;
  logic [31:0]  count_q, count_d;
  logic         fault_q, fault_d;

  assign pc_plus4 = pc_q + 32'd4;

  // imem_instr_i is only routed into if_id_d on the capture branch, so an
  // undriven word in any other cycle never reaches the register.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if_id_d = if_id_q;
    count_d = count_q;
    fault_d = fault_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid_i && (redirect_pc_i[1:0] != 2'b00)) begin
          state_d       = FAULT;
          fault_d       = 1'b1;
          if_id_d.valid = 1'b0;
          if_id_d.instr = NOP_INSTR;
        end else if (redirect_valid_i) begin
          pc_d          = redirect_pc_i;
          if_id_d.valid = 1'b0;
          if_id_d.instr = NOP_INSTR;
        end else if (!stall_i) begin
          if_id_d = '{valid: 1'b1, pc: pc_q, pc_plus4: pc_plus4, instr: imem_instr_i};
          pc_d    = pc_plus4;
          count_d = count_q + 32'd1;
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= BASE_PC;
      if_id_q <= IF_ID_RESET;
      count_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  assign imem_pc_o        = pc_q;
  assign if_id_valid_o    = if_id_q.valid;
  assign if_id_pc_o       = if_id_q.pc;
  assign if_id_pc_plus4_o = if_id_q.pc_plus4;
  assign if_id_instr_o    = if_id_q.instr;
  assign fault_o          = fault_q;
  assign fetch_count_o    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a behavioural
// model of the PC / IF/ID rules, with directed boundary scenarios.
module tb_fetch_stage;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_pc_o;
  logic [31:0] imem_instr_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc_plus4_o;
  logic [31:0] if_id_instr_o;
  logic        fault_o;
  logic [31:0] fetch_count_o;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_count;
  logic        m_valid, m_fault;
  bit          m_boot;

  fetch_stage #(.BASE_PC(BASE), .NOP_INSTR(NOPW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .imem_pc_o(imem_pc_o), .imem_instr_i(imem_instr_i),
    .if_id_valid_o(if_id_valid_o), .if_id_pc_o(if_id_pc_o),
    .if_id_pc_plus4_o(if_id_pc_plus4_o), .if_id_instr_o(if_id_instr_o),
    .fault_o(fault_o), .fetch_count_o(fetch_count_o)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: an arbitrary but deterministic word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always_comb imem_instr_i = mem_word(imem_pc_o);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("imem_pc",  imem_pc_o, m_pc);
    checkOutput("valid",    {31'd0, if_id_valid_o}, {31'd0, m_valid});
    checkOutput("if_pc",    if_id_pc_o, m_ipc);
    checkOutput("if_pc4",   if_id_pc_plus4_o, m_ipc4);
    checkOutput("instr",    if_id_instr_o, m_instr);
    checkOutput("fault",    {31'd0, fault_o}, {31'd0, m_fault});
    checkOutput("count",    fetch_count_o, m_count);
  endtask

  task automatic modelReset();
    m_pc = BASE; m_valid = 1'b0; m_ipc = BASE; m_ipc4 = BASE + 32'd4;
    m_instr = NOPW; m_fault = 1'b0; m_count = 32'd0; m_boot = 1'b1;
  endtask

  // One clock edge of the fetch rules: boot bubble, fault lock, then
  // misaligned redirect > redirect > stall > capture.
  task automatic modelStep(input bit stl, input bit red, input logic [31:0] rpc);
    if (m_fault) return;
    if (m_boot) begin
      m_boot = 1'b0;
      return;
    end
    if (red && (rpc % 4 != 0)) begin
      m_fault = 1'b1; m_valid = 1'b0; m_instr = NOPW;
    end else if (red) begin
      m_pc = rpc; m_valid = 1'b0; m_instr = NOPW;
    end else if (!stl) begin
      m_valid = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
      m_instr = mem_word(m_pc); m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
    end
  endtask

  task automatic applyStimulus(input bit stl, input bit red, input logic [31:0] rpc);
    stall_i = stl; redirect_valid_i = red; redirect_pc_i = rpc;
    @(posedge clk);
    modelStep(stl, red, rpc);
    @(negedge clk);
    checkAll();
  endtask

  // Asserts reset between edges, checks outputs settle before the next edge, releases on a negedge.
  task automatic asyncReset();
    #2 rst_n = 1'b0;
    #1 modelReset();
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'd0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    rst_n = 1'b1;

    // Boot bubble then sequential fetch up to pc 0x10
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("pc_at_0x10", imem_pc_o, 32'h10);

    // Stall three cycles, then capture
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("post_stall_pc", if_id_pc_o, 32'h10);

    // Redirect wins over stall
    applyStimulus(1'b1, 1'b1, 32'h40);
    checkOutput("redir_instr", if_id_instr_o, NOPW);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("redir_cap", if_id_pc_o, 32'h40);

    // PC wraparound
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("wrap_pc4", if_id_pc_plus4_o, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'd0);

    // Misaligned redirect locks the stage
    applyStimulus(1'b0, 1'b1, 32'h42);
    checkOutput("fault_set", {31'd0, fault_o}, 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom & ~32'h3);
    asyncReset();

    // Async reset mid-run at pc 0x20, boot bubble repeats
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("pc_at_0x20", imem_pc_o, 32'h20);
    asyncReset();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("boot_again", {31'd0, if_id_valid_o}, 32'd0);

    // Randomized traffic with occasional resets to leave FAULT
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      bit stl, red;
      stl = ($urandom_range(0, 3) == 0);
      red = ($urandom_range(0, 7) == 0);
      tgt = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 15) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      applyStimulus(stl, red, tgt);
      if (m_fault && $urandom_range(0, 3) == 0) asyncReset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
